// File: rtl/mem_pkg.sv
// Shared memOp encodings for the data-memory path (ctrl, RF and dmem).
package mem_pkg;

  localparam int unsigned MEMOP_BITS = 2;

  localparam logic [MEMOP_BITS-1:0] MEMOP_W   = 2'b00;
  localparam logic [MEMOP_BITS-1:0] MEMOP_H   = 2'b01;
  localparam logic [MEMOP_BITS-1:0] MEMOP_B   = 2'b10;
  localparam logic [MEMOP_BITS-1:0] MEMOP_RSV = 2'b11;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 16;

endpackage

// File: rtl/dmem_if.sv
// Core <-> data-memory bus, including the debug read port and status.
interface dmem_if #(
  parameter int unsigned IDX_W = 7
);
  import mem_pkg::*;

  logic                  MemWrite;
  logic [MEMOP_BITS-1:0] memOp;
  logic [DATA_W-1:0]     addr;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic [IDX_W-1:0]      dm_sel;
  logic [DATA_W-1:0]     dm_data;
  logic                  misalign;
  logic [DATA_W-1:0]     err_addr;
  logic [CNT_W-1:0]      store_cnt;

  modport master (
    output MemWrite, memOp, addr, writedata, dm_sel,
    input  readdata, dm_data, misalign, err_addr, store_cnt
  );

  modport slave (
    input  MemWrite, memOp, addr, writedata, dm_sel,
    output readdata, dm_data, misalign, err_addr, store_cnt
  );

endinterface

// File: rtl/dmem_lane.sv
// Store lane steering: byte enables, lane-replicated write word, legality.
module dmem_lane
  import mem_pkg::*;
(
  input  logic [MEMOP_BITS-1:0] i_mem_op,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [BE_W-1:0]       o_be_c,
  output logic [DATA_W-1:0]     o_wword_c,
  output logic                  o_illegal_c
);

  // Decode size/alignment into enables; data is replicated so any lane can pick it up
  always_comb begin
    o_be_c      = '0;
    o_wword_c   = i_wdata;
    o_illegal_c = 1'b0;
    case (i_mem_op)
      MEMOP_W: begin
        o_illegal_c = |i_addr_lo;
        o_be_c      = 4'b1111;
        o_wword_c   = i_wdata;
      end
      MEMOP_H: begin
        o_illegal_c = i_addr_lo[0];
        o_be_c      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword_c   = {2{i_wdata[15:0]}};
      end
      MEMOP_B: begin
        o_be_c    = BE_W'(4'b0001 << i_addr_lo);
        o_wword_c = {4{i_wdata[7:0]}};
      end
      default: begin
        o_illegal_c = 1'b1;
        o_be_c      = '0;
      end
    endcase
    if (o_illegal_c) o_be_c = '0;
  end

endmodule

// File: rtl/dmem.sv
// Data memory: byte-lane stores, combinational reads, error capture, store counter.
module dmem
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128
)(
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic              r_misalign;
  logic [DATA_W-1:0] r_err_addr;
  logic [CNT_W-1:0]  r_store_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wword;
  logic              w_illegal;
  logic              w_st_ok;
  logic              w_st_bad;
  logic              w_unused;

  assign w_idx    = bus.addr[IDX_W+1:2];
  assign w_st_ok  = bus.MemWrite & ~w_illegal;
  assign w_st_bad = bus.MemWrite &  w_illegal;
  assign w_unused = ^bus.addr[DATA_W-1:IDX_W+2];

  dmem_lane u_lane (
    .i_mem_op    (bus.memOp),
    .i_addr_lo   (bus.addr[1:0]),
    .i_wdata     (bus.writedata),
    .o_be_c      (w_be),
    .o_wword_c   (w_wword),
    .o_illegal_c (w_illegal)
  );

  // Storage: clear on reset, per-byte write on legal stores
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) r_mem[i] <= '0;
    end else if (w_st_ok) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  // Sticky error flag; address of the first illegal store only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
      r_err_addr <= '0;
    end else if (w_st_bad) begin
      r_misalign <= 1'b1;
      if (!r_misalign) r_err_addr <= bus.addr;
    end
  end

  // Saturating count of completed stores
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_store_cnt <= '0;
    end else if (w_st_ok && (r_store_cnt != {CNT_W{1'b1}})) begin
      r_store_cnt <= r_store_cnt + CNT_W'(1);
    end
  end

  assign bus.readdata  = r_mem[w_idx];
  assign bus.dm_data   = r_mem[bus.dm_sel];
  assign bus.misalign  = r_misalign;
  assign bus.err_addr  = r_err_addr;
  assign bus.store_cnt = r_store_cnt;

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem.
module tb_dmem;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  dmem_if #(.IDX_W(7)) bus ();

  dmem #(.DEPTH_WORDS(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.memOp     = op;
    bus.addr      = a;
    bus.writedata = d;
    @(posedge clk);
    #1;
    bus.MemWrite  = 1'b0;
  endtask

  task automatic test_reset;
    do_store(MEMOP_W, 32'h0000_0010, 32'h1234_5678);
    do_store(MEMOP_W, 32'h0000_01FC, 32'h8765_4321);
    do_store(MEMOP_W, 32'h0000_0003, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (bus.misalign !== 1'b0) begin
      n_err++; $display("FAIL reset_misalign got=%0b exp=0", bus.misalign);
    end
    n_chk++;
    if (bus.err_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_err_addr got=%h exp=0", bus.err_addr);
    end
    n_chk++;
    if (bus.store_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_store_cnt got=%h exp=0", bus.store_cnt);
    end
    for (int i = 0; i < 128; i++) begin
      bus.addr   = 32'(i * 4);
      bus.dm_sel = 7'(i);
      #1;
      n_chk++;
      if (bus.readdata !== 32'h0 || bus.dm_data !== 32'h0) begin
        n_err++; $display("FAIL reset_word idx=%0d rd=%h dm=%h exp=0", i, bus.readdata, bus.dm_data);
      end
    end
    // store attempted while reset is held must not land
    bus.MemWrite  = 1'b1;
    bus.memOp     = MEMOP_W;
    bus.addr      = 32'h10;
    bus.writedata = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    n_chk++;
    if (bus.readdata !== 32'h0 || bus.store_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_blocks_write rd=%h cnt=%h exp=0/0", bus.readdata, bus.store_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word_store;
    do_store(MEMOP_W, 32'h10, 32'hDEAD_BEEF);
    bus.dm_sel = 7'd4;
    #1;
    n_chk++;
    if (bus.readdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL word_rd got=%h exp=deadbeef", bus.readdata);
    end
    n_chk++;
    if (bus.dm_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL word_dm got=%h exp=deadbeef", bus.dm_data);
    end
    n_chk++;
    if (bus.store_cnt !== 16'd1) begin
      n_err++; $display("FAIL word_cnt got=%h exp=1", bus.store_cnt);
    end
  endtask

  task automatic test_sub_word;
    // old word visible until the writing edge
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.memOp     = MEMOP_B;
    bus.addr      = 32'h13;
    bus.writedata = 32'h1234_56AB;
    #1;
    n_chk++;
    if (bus.readdata !== 32'hDEAD_BEEF || bus.dm_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL rdw_old rd=%h dm=%h exp=deadbeef", bus.readdata, bus.dm_data);
    end
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    n_chk++;
    if (bus.readdata !== 32'hABAD_BEEF) begin
      n_err++; $display("FAIL byte3 got=%h exp=abadbeef", bus.readdata);
    end
    do_store(MEMOP_H, 32'h12, 32'h0000_CAFE);
    n_chk++;
    if (bus.readdata !== 32'hCAFE_BEEF) begin
      n_err++; $display("FAIL half_hi got=%h exp=cafebeef", bus.readdata);
    end
    do_store(MEMOP_H, 32'h10, 32'h0000_CAFE);
    n_chk++;
    if (bus.readdata !== 32'hCAFE_CAFE) begin
      n_err++; $display("FAIL half_lo got=%h exp=cafecafe", bus.readdata);
    end
    do_store(MEMOP_B, 32'h11, 32'hFFFF_FF55);
    n_chk++;
    if (bus.readdata !== 32'hCAFE_55FE) begin
      n_err++; $display("FAIL byte1 got=%h exp=cafe55fe", bus.readdata);
    end
    do_store(MEMOP_B, 32'h10, 32'h0000_0077);
    n_chk++;
    if (bus.readdata !== 32'hCAFE_5577 || bus.store_cnt !== 16'd6) begin
      n_err++; $display("FAIL byte0 rd=%h cnt=%h exp=cafe5577/6", bus.readdata, bus.store_cnt);
    end
  endtask

  task automatic test_no_write;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
    bus.memOp     = MEMOP_RSV;
    bus.addr      = 32'h01;
    bus.writedata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus.memOp = MEMOP_W;
    bus.addr  = 32'h10;
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.misalign !== 1'b0 || bus.store_cnt !== 16'd6 || bus.readdata !== 32'hCAFE_5577) begin
      n_err++; $display("FAIL idle_no_change mis=%0b cnt=%h rd=%h exp=0/6/cafe5577",
                        bus.misalign, bus.store_cnt, bus.readdata);
    end
  endtask

  task automatic test_illegal;
    do_store(MEMOP_W, 32'h22, 32'hFFFF_FFFF);
    n_chk++;
    if (bus.misalign !== 1'b1 || bus.err_addr !== 32'h22) begin
      n_err++; $display("FAIL ill_first mis=%0b ea=%h exp=1/22", bus.misalign, bus.err_addr);
    end
    do_store(MEMOP_H, 32'h31, 32'hFFFF_FFFF);
    do_store(MEMOP_RSV, 32'h40, 32'hFFFF_FFFF);
    n_chk++;
    if (bus.misalign !== 1'b1 || bus.err_addr !== 32'h22 || bus.store_cnt !== 16'd6) begin
      n_err++; $display("FAIL ill_sticky mis=%0b ea=%h cnt=%h exp=1/22/6",
                        bus.misalign, bus.err_addr, bus.store_cnt);
    end
    bus.addr = 32'h20; #1;
    n_chk++;
    if (bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL ill_mem20 got=%h exp=0", bus.readdata);
    end
    bus.addr = 32'h30; #1;
    n_chk++;
    if (bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL ill_mem30 got=%h exp=0", bus.readdata);
    end
    bus.addr = 32'h40; #1;
    n_chk++;
    if (bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL ill_mem40 got=%h exp=0", bus.readdata);
    end
  endtask

  task automatic test_alias;
    do_store(MEMOP_W, 32'h204, 32'h1111_1111);
    bus.addr   = 32'h004;
    bus.dm_sel = 7'd1;
    #1;
    n_chk++;
    if (bus.readdata !== 32'h1111_1111 || bus.dm_data !== 32'h1111_1111) begin
      n_err++; $display("FAIL alias rd=%h dm=%h exp=11111111", bus.readdata, bus.dm_data);
    end
    bus.addr = 32'h10; #1;
    n_chk++;
    if (bus.readdata !== 32'hCAFE_5577 || bus.store_cnt !== 16'd7) begin
      n_err++; $display("FAIL alias_other rd=%h cnt=%h exp=cafe5577/7", bus.readdata, bus.store_cnt);
    end
  endtask

  task automatic test_saturate;
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.memOp     = MEMOP_B;
    bus.addr      = 32'h08;
    bus.writedata = 32'h0000_005A;
    repeat (65540) @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    n_chk++;
    if (bus.store_cnt !== 16'hFFFF || bus.readdata !== 32'h0000_005A) begin
      n_err++; $display("FAIL sat cnt=%h rd=%h exp=ffff/0000005a", bus.store_cnt, bus.readdata);
    end
    do_store(MEMOP_B, 32'h09, 32'h0000_00C3);
    n_chk++;
    if (bus.store_cnt !== 16'hFFFF || bus.readdata !== 32'h0000_C35A) begin
      n_err++; $display("FAIL sat_hold cnt=%h rd=%h exp=ffff/0000c35a", bus.store_cnt, bus.readdata);
    end
  endtask

  task automatic test_reset_clears_error;
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    bus.addr = 32'h08; #1;
    n_chk++;
    if (bus.misalign !== 1'b0 || bus.err_addr !== 32'h0 || bus.store_cnt !== 16'h0 ||
        bus.readdata !== 32'h0) begin
      n_err++; $display("FAIL reset2 mis=%0b ea=%h cnt=%h rd=%h exp=0/0/0/0",
                        bus.misalign, bus.err_addr, bus.store_cnt, bus.readdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_err         = 0;
    n_chk         = 0;
    rst           = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.memOp     = MEMOP_W;
    bus.addr      = '0;
    bus.writedata = '0;
    bus.dm_sel    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_word_store();
    test_sub_word();
    test_no_write();
    test_illegal();
    test_alias();
    test_saturate();
    test_reset_clears_error();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
